// File: rtl/sram_lsu_ctrl.sv
// Load/store sequencer in front of a word-wide single-port SRAM.
// Sub-word stores are done as read-modify-write; big-endian byte lanes.
module sram_lsu_ctrl #(
    parameter int D_WIDTH  = 32,
    parameter int SA_WIDTH = 10
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Req,
    input  logic                  Wr,
    input  logic [1:0]            Size,
    input  logic                  Sgn,
    input  logic [SA_WIDTH+1:0]   Addr_In,
    input  logic [D_WIDTH-1:0]    Wdata,
    output logic                  Ready,
    output logic                  Done,
    output logic                  Err,
    output logic [D_WIDTH-1:0]    Rdata,
    output logic                  Sram_En,
    output logic                  Sram_RW,
    output logic [SA_WIDTH-1:0]   Sram_Addr,
    output logic [D_WIDTH-1:0]    Sram_Din,
    input  logic [D_WIDTH-1:0]    Sram_Dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_WRITE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_wr;
    logic [1:0]            r_size;
    logic                  r_sgn;
    logic [SA_WIDTH+1:0]   r_addr;
    logic [15:0]           r_wdata;
    logic                  r_done;
    logic                  r_err;
    logic [D_WIDTH-1:0]    r_rdata;
    logic [D_WIDTH-1:0]    r_din;

    logic                  w_accept;
    logic                  w_bad;
    logic                  w_word_st;
    logic [1:0]            w_boff;
    logic [4:0]            w_bpos;
    logic [4:0]            w_hpos;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [D_WIDTH-1:0]    w_fmt;
    logic [D_WIDTH-1:0]    w_merged;

    assign w_accept  = Req & Ready;
    assign w_bad     = (Size == 2'b11)
                     | ((Size == 2'b01) & Addr_In[0])
                     | ((Size == 2'b10) & (|Addr_In[1:0]));
    assign w_word_st = Wr & (Size == 2'b10);

    // Big-endian: byte offset 0 is the most significant lane
    assign w_boff = ~r_addr[1:0];
    assign w_bpos = {w_boff, 3'b000};
    assign w_hpos = {~r_addr[1], 4'b0000};
    assign w_byte = Sram_Dout[w_bpos +: 8];
    assign w_half = Sram_Dout[w_hpos +: 16];

    always_comb begin
        w_fmt = Sram_Dout;
        unique case (r_size)
            2'b00:   w_fmt = {{24{r_sgn & w_byte[7]}}, w_byte};
            2'b01:   w_fmt = {{16{r_sgn & w_half[15]}}, w_half};
            default: w_fmt = Sram_Dout;
        endcase
    end

    always_comb begin
        w_merged = Sram_Dout;
        if (r_size == 2'b00)
            w_merged[w_bpos +: 8] = r_wdata[7:0];
        else
            w_merged[w_hpos +: 16] = r_wdata;
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && !w_bad)
                    w_next = w_word_st ? S_WRITE : S_READ;
            end
            S_READ:  w_next = S_CAPT;
            S_CAPT:  w_next = r_wr ? S_WRITE : S_IDLE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Ready   = (r_state == S_IDLE) & ~Rst;
        Sram_En = 1'b0;
        Sram_RW = 1'b0;
        unique case (r_state)
            S_READ: begin
                Sram_En = 1'b1;
            end
            S_WRITE: begin
                Sram_En = 1'b1;
                Sram_RW = 1'b1;
            end
            default: begin
                Sram_En = 1'b0;
                Sram_RW = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr    <= 1'b0;
            r_size  <= 2'b00;
            r_sgn   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_din   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_accept) begin
                r_wr    <= Wr;
                r_size  <= Size;
                r_sgn   <= Sgn;
                r_addr  <= Addr_In;
                r_wdata <= Wdata[15:0];
                if (w_bad) begin
                    r_done <= 1'b1;
                    r_err  <= 1'b1;
                end else if (w_word_st) begin
                    r_din <= Wdata;
                end
            end
            if (r_state == S_CAPT) begin
                if (r_wr) begin
                    r_din <= w_merged;
                end else begin
                    r_rdata <= w_fmt;
                    r_done  <= 1'b1;
                end
            end
            if (r_state == S_WRITE)
                r_done <= 1'b1;
        end
    end

    assign Done      = r_done;
    assign Err       = r_err;
    assign Rdata     = r_rdata;
    assign Sram_Addr = r_addr[SA_WIDTH+1:2];
    assign Sram_Din  = r_din;

endmodule
